// File: rtl/uart_rx_core_if.sv
// Holding-register handshake between the UART receive core (slave) and the bus-side wrapper (master).
// UART_RX_PARITY_EN adds the parity sense select and the parity error flag.
interface uart_rx_core_if;
    logic       rd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       ferr;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       perr;

    modport master (output rd, parity_odd,
                    input  rx_data, rx_ready, ferr, overrun, busy, perr);
    modport slave  (input  rd, parity_odd,
                    output rx_data, rx_ready, ferr, overrun, busy, perr);
`else
    modport master (output rd,
                    input  rx_data, rx_ready, ferr, overrun, busy);
    modport slave  (input  rd,
                    output rx_data, rx_ready, ferr, overrun, busy);
`endif
endinterface

// File: rtl/uart_rx_core.sv
// UART receive datapath: 16x-oversampled deserialiser feeding a one-deep holding register.
// Define UART_RX_PARITY_EN to receive and check one parity bit after the data bits.
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int OS_LOG2   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_rx,
    input  logic          rxd,
    uart_rx_core_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [OS_LOG2-1:0] CNT_MID  = {1'b0, {(OS_LOG2-1){1'b1}}};
    localparam logic [OS_LOG2-1:0] CNT_LAST = {OS_LOG2{1'b1}};
    localparam logic [3:0]         LAST_BIT = 4'(DATA_BITS - 1);

    logic                 rxd_meta;
    logic                 rxd_s;
    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [OS_LOG2-1:0]   tick_cnt;
    logic [OS_LOG2-1:0]   tick_cnt_next;
    logic [3:0]           bit_idx;
    logic [3:0]           bit_idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic                 sample;
    logic                 load;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_capture;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Start edge is looked for every clk; after that all decisions wait for oversample ticks.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_idx_next  = bit_idx;
        sample        = 1'b0;
        load          = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture   = 1'b0;
`endif
        if (state != IDLE && en_rx)
            tick_cnt_next = tick_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (en_rx && tick_cnt == CNT_MID) begin
                    tick_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (en_rx && tick_cnt == CNT_LAST) begin
                    sample       = 1'b1;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (en_rx && tick_cnt == CNT_LAST) begin
                    par_capture = 1'b1;
                    state_next  = STOP;
                end
            end
`endif
            STOP: begin
                if (en_rx && tick_cnt == CNT_LAST) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                tick_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_idx  <= bit_idx_next;
            bus.busy <= (state_next != IDLE);
            if (sample)
                shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit  <= 1'b0;
            bus.perr <= 1'b0;
        end else begin
            if (par_capture)
                par_bit <= rxd_s;
            if (load)
                bus.perr <= (^shreg) ^ par_bit ^ bus.parity_odd;
        end
    end
`endif

    // A load in the same cycle as rd treats the old byte as consumed, so no overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rx_data  <= '0;
            bus.rx_ready <= 1'b0;
            bus.ferr     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else if (load) begin
            bus.rx_data  <= 8'(shreg);
            bus.rx_ready <= 1'b1;
            bus.ferr     <= ~rxd_s;
            if (bus.rd)
                bus.overrun <= 1'b0;
            else if (bus.rx_ready)
                bus.overrun <= 1'b1;
        end else if (bus.rd && bus.rx_ready) begin
            bus.rx_ready <= 1'b0;
            bus.overrun  <= 1'b0;
        end
    end
endmodule
